// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int          XLEN_DEFAULT = 64;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Output register stage toward decode: holds one instruction and its PC.
// Handshake: valid_o is raised by load_i and stays up, with data/pc stable,
// until the consumer asserts ready (consume_i) in a cycle where valid_o=1;
// flush_i drops valid_o unconditionally and wins over load and consume.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            consume_i,
  input  logic [31:0]     data_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     data_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [31:0]     data_q,  data_d;
  logic [XLEN-1:0] pc_q,    pc_d;

  // Next-value selection: flush > load > consume > hold. Payload only moves on load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (consume_i && valid_q) begin
      valid_d = 1'b0;
    end
  end

  // Stage registers with synchronous reset to an empty NOP slot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC, addresses the combinational instruction
// memory, and registers each fetched word into a valid/ready stage for decode.
// Handshake: a transfer to decode happens on any clock edge where
// if_valid && if_ready; while if_valid && !if_ready the stage and pc are frozen.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter int              IMEM_WORDS = 128,
  parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [31:0]     fetch_count,
  output logic [1:0]      dbg_state
);

  // First byte address past the end of instruction memory.
  localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_WORDS) << 2;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic [31:0]     count_q, count_d;

  logic stage_free;
  logic handshake;
  logic pc_illegal;
  logic fetch_attempt;
  logic legal_fetch;
  logic illegal_fetch;

  // Fetch qualification: only in RUN, with room in the stage and no redirect.
  always_comb begin
    handshake     = if_valid && if_ready;
    stage_free    = !if_valid || if_ready;
    pc_illegal    = (pc_q[1:0] != 2'b00) || (pc_q >= IMEM_LIMIT);
    fetch_attempt = (state_q == RUN) && stage_free && !redirect_valid;
    legal_fetch   = fetch_attempt && !pc_illegal;
    illegal_fetch = fetch_attempt && pc_illegal;
  end

  // Next state plus PC, fault and counter updates; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    if (handshake) begin
      count_d = sat_inc32(count_q);
    end

    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = redirect_pc;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (illegal_fetch) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
          end else if (legal_fetch) begin
            pc_d = pc_q + PC_STEP;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = BOOT;
      endcase
    end
  end

  // Control and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  fetch_out_reg #(
    .XLEN (XLEN)
  ) u_out_reg (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (legal_fetch),
    .flush_i   (redirect_valid || illegal_fetch),
    .consume_i (if_ready),
    .data_i    (imem_rdata),
    .pc_i      (pc_q),
    .valid_o   (if_valid),
    .data_o    (if_instr),
    .pc_o      (if_pc)
  );

  assign imem_addr   = pc_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller with a behavioural instruction memory.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int XLEN       = 64;
  localparam int IMEM_WORDS = 128;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            fault;
  logic [XLEN-1:0] fault_pc;
  logic [31:0]     fetch_count;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  fetch_controller #(
    .XLEN       (XLEN),
    .IMEM_WORDS (IMEM_WORDS),
    .RESET_PC   (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count),
    .dbg_state      (dbg_state)
  );

  // Instruction memory model: combinational read, out-of-range returns a marker.
  logic [31:0] mem [IMEM_WORDS];
  always_comb begin
    if (imem_addr < 64'd512) imem_rdata = mem[imem_addr[8:2]];
    else                     imem_rdata = 32'hBAD0_BAD0;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [95:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_q.push_back({pc, mem[pc[8:2]]});
  endtask

  // Every completed handshake must match the oldest expected fetch.
  always @(negedge clk) begin : monitor
    logic [95:0] e;
    if (!reset && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e[95:32]);
        check("sb_instr", {32'h0, if_instr}, {32'h0, e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  imem_addr, 64'h0);
    check({tag, "_valid"}, {63'h0, if_valid}, 64'h0);
    check({tag, "_instr"}, {32'h0, if_instr}, {32'h0, NOP_INSTR});
    check({tag, "_ifpc"},  if_pc, 64'h0);
    check({tag, "_fault"}, {63'h0, fault}, 64'h0);
    check({tag, "_fpc"},   fault_pc, 64'h0);
    check({tag, "_count"}, {32'h0, fetch_count}, 64'h0);
    check({tag, "_state"}, {62'h0, dbg_state}, {62'h0, BOOT});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [63:0] last_pc;
    int          k;

    for (int i = 0; i < IMEM_WORDS; i++)
      mem[i] = {16'($urandom_range(0, 65535)), 16'(i)};

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    step();
    step();
    check_reset_outputs("rst");

    // Boot sequence and streaming from RESET_PC.
    for (int a = 0; a <= 16; a += 4) push_exp(64'(a));
    reset = 1'b0;
    step();
    check("boot_valid", {63'h0, if_valid}, 64'h0);
    check("boot_state", {62'h0, dbg_state}, {62'h0, RUN});
    step();
    check("first_valid", {63'h0, if_valid}, 64'h1);
    check("first_pc", if_pc, 64'h0);
    check("first_instr", {32'h0, if_instr}, {32'h0, mem[0]});
    step();
    check("pc4", if_pc, 64'h4);
    step();
    check("pc8", if_pc, 64'h8);
    check("cnt2", {32'h0, fetch_count}, 64'd2);
    check("addr12", imem_addr, 64'hC);

    // Stall for three cycles with if_pc = 8.
    if_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      check("stall_pc", if_pc, 64'h8);
      check("stall_instr", {32'h0, if_instr}, {32'h0, mem[2]});
      check("stall_addr", imem_addr, 64'hC);
      check("stall_cnt", {32'h0, fetch_count}, 64'd2);
    end
    if_ready = 1'b1;
    step();
    check("unstall_pc", if_pc, 64'hC);
    check("cnt3", {32'h0, fetch_count}, 64'd3);
    step();
    check("pc16", if_pc, 64'h10);
    check("cnt4", {32'h0, fetch_count}, 64'd4);

    // Redirect coinciding with a completed handshake.
    push_exp(64'h40);
    push_exp(64'h44);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    step();
    redirect_valid = 1'b0;
    check("redir_cnt", {32'h0, fetch_count}, 64'd5);
    check("redir_bubble", {63'h0, if_valid}, 64'h0);
    check("redir_addr", imem_addr, 64'h40);
    step();
    check("redir_valid", {63'h0, if_valid}, 64'h1);
    check("redir_pc", if_pc, 64'h40);
    step();
    check("redir_pc2", if_pc, 64'h44);
    check("cnt6", {32'h0, fetch_count}, 64'd6);

    // Redirect to a misaligned target faults at the next fetch attempt.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h42;
    step();
    redirect_valid = 1'b0;
    check("mis_cnt", {32'h0, fetch_count}, 64'd7);
    check("mis_nofault_yet", {63'h0, fault}, 64'h0);
    step();
    check("mis_fault", {63'h0, fault}, 64'h1);
    check("mis_fault_pc", fault_pc, 64'h42);
    check("mis_valid", {63'h0, if_valid}, 64'h0);
    check("mis_state", {62'h0, dbg_state}, {62'h0, FAULT});
    step();
    check("mis_sticky", {63'h0, fault}, 64'h1);
    check("mis_addr_hold", imem_addr, 64'h42);

    // Recover with a legal redirect.
    push_exp(64'h20);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h20;
    step();
    check("rec_fault_clr", {63'h0, fault}, 64'h0);
    check("rec_bubble", {63'h0, if_valid}, 64'h0);
    redirect_valid = 1'b0;
    step();
    check("rec_valid", {63'h0, if_valid}, 64'h1);
    check("rec_pc", if_pc, 64'h20);

    // Run off the end of instruction memory.
    for (int a = 'h1F0; a <= 'h1FC; a += 4) push_exp(64'(a));
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1F0;
    step();
    redirect_valid = 1'b0;
    last_pc = '1;
    k = 0;
    while (k < 20 && !fault) begin
      step();
      if (if_valid) last_pc = if_pc;
      k++;
    end
    check("end_timeout", {63'h0, fault}, 64'h1);
    check("end_fault_pc", fault_pc, 64'h200);
    check("end_last_pc", last_pc, 64'h1FC);
    check("end_valid", {63'h0, if_valid}, 64'h0);
    check("end_cnt", {32'h0, fetch_count}, 64'd12);

    // Reset during a stall while faulted; reset beats a concurrent redirect.
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80;
    reset          = 1'b1;
    step();
    check_reset_outputs("midrst");
    reset          = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    push_exp(64'h0);
    step();
    check("resume_boot_valid", {63'h0, if_valid}, 64'h0);
    step();
    check("resume_valid", {63'h0, if_valid}, 64'h1);
    check("resume_pc", if_pc, 64'h0);

    // Random backpressure over a longer sequential stream.
    for (int a = 4; a <= 160; a += 4) push_exp(64'(a));
    k = 0;
    while (k < 600 && exp_q.size() != 0) begin
      if_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    if_ready = 1'b0;
    check("rand_drain", 64'(exp_q.size()), 64'd0);
    check("rand_cnt", {32'h0, fetch_count}, 64'd41);
    step();
    check("rand_hold_pc", if_pc, 64'd164);
    check("rand_fault", {63'h0, fault}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
